// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with combinational peek, registered pop, replace-top and sticky errors.
// Optional high-water mark output enabled by defining LIFO_STACK_WATERMARK_EN.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_enable,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_enable,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top_data,
  input  logic             flush,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
`ifdef LIFO_STACK_WATERMARK_EN
  output logic [CNT_W-1:0] hwm,
`endif
  output logic             underflow
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count_next;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             do_push;
  logic             do_pop;
  logic             pop_ok;
  logic             replace;
  logic             push_ok;
  logic             ovf_set;
  logic             unf_set;

  // Flush masks both requests so nothing else (including error flags) reacts.
  assign do_push = push_enable & ~flush;
  assign do_pop  = pop_enable & ~flush;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign wr_idx  = IDX_W'(count);
  assign top_idx = IDX_W'(count - CNT_W'(1));

  assign pop_ok  = do_pop & ~empty;
  assign replace = do_push & pop_ok;
  assign push_ok = do_push & ~pop_ok & ~full;
  assign ovf_set = do_push & ~do_pop & full;
  assign unf_set = do_pop & empty;

  assign top_data = empty ? '0 : mem[top_idx];

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push_ok)
      count_next = count + CNT_W'(1);
    else if (pop_ok && !replace)
      count_next = count - CNT_W'(1);
  end

  // Storage is deliberately not reset; empty gates every read path.
  always_ff @(posedge clk) begin
    if (replace)
      mem[top_idx] <= push_data;
    else if (push_ok)
      mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      pop_valid <= pop_ok;
      if (pop_ok)
        pop_data <= mem[top_idx];
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

`ifdef LIFO_STACK_WATERMARK_EN
  // A clear coinciding with a rising count keeps the new level rather than zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hwm <= '0;
    else if (err_clr)
      hwm <= (count_next > count) ? count_next : '0;
    else if (count_next > hwm)
      hwm <= count_next;
  end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: queue-based reference model, directed test plan, random traffic.
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push_enable = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             pop_enable = 1'b0;
  logic             flush = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef LIFO_STACK_WATERMARK_EN
  logic [CNT_W-1:0] hwm;
`endif

  int n_vec = 0;
  int n_err = 0;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .push_enable(push_enable),
    .push_data(push_data),
    .pop_enable(pop_enable),
    .pop_data(pop_data),
    .pop_valid(pop_valid),
    .top_data(top_data),
    .flush(flush),
    .err_clr(err_clr),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow),
`ifdef LIFO_STACK_WATERMARK_EN
    .hwm(hwm),
`endif
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] stk [$];
  logic [WIDTH-1:0] m_pop_data = '0;
  bit               m_pop_valid = 1'b0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;
  int               m_hwm = 0;
  int               old_n;
  bit               o_set;
  bit               u_set;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk.delete();
      m_pop_data  = '0;
      m_pop_valid = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
      m_hwm       = 0;
    end else begin
      old_n       = stk.size();
      o_set       = 1'b0;
      u_set       = 1'b0;
      m_pop_valid = 1'b0;
      if (flush) begin
        stk.delete();
      end else if (push_enable && pop_enable) begin
        if (old_n > 0) begin
          m_pop_data  = stk[old_n-1];
          m_pop_valid = 1'b1;
          stk[old_n-1] = push_data;
        end else begin
          u_set = 1'b1;
          stk.push_back(push_data);
        end
      end else if (push_enable) begin
        if (old_n < DEPTH) stk.push_back(push_data);
        else o_set = 1'b1;
      end else if (pop_enable) begin
        if (old_n > 0) begin
          m_pop_data  = stk.pop_back();
          m_pop_valid = 1'b1;
        end else begin
          u_set = 1'b1;
        end
      end
      m_ovf = o_set || (m_ovf && !err_clr);
      m_unf = u_set || (m_unf && !err_clr);
      if (err_clr) m_hwm = (stk.size() > old_n) ? stk.size() : 0;
      else if (stk.size() > m_hwm) m_hwm = stk.size();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are compared on the falling edge, half a cycle clear of any update.
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(stk.size()));
    chk("empty", 32'(empty), 32'(stk.size() == 0));
    chk("full", 32'(full), 32'(stk.size() == DEPTH));
    chk("top_data", 32'(top_data), (stk.size() == 0) ? 32'd0 : 32'(stk[stk.size()-1]));
    chk("pop_valid", 32'(pop_valid), 32'(m_pop_valid));
    chk("pop_data", 32'(pop_data), 32'(m_pop_data));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef LIFO_STACK_WATERMARK_EN
    chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
  end

  // Entered and left at one time unit after a falling edge; covers exactly one rising edge.
  task automatic cycle(input bit pu, input logic [WIDTH-1:0] d, input bit po,
                       input bit fl, input bit ec);
    push_enable = pu;
    push_data   = d;
    pop_enable  = po;
    flush       = fl;
    err_clr     = ec;
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("lit_reset_count", 32'(count), 32'd0);
    chk("lit_reset_valid", 32'(pop_valid), 32'd0);
    chk("lit_reset_top", 32'(top_data), 32'd0);
    rst = 1'b1;

    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    chk("lit_push3_count", 32'(count), 32'd3);
    chk("lit_push3_top", 32'(top_data), 32'h33);
    chk("lit_push3_empty", 32'(empty), 32'd0);
    chk("lit_push3_full", 32'(full), 32'd0);

    cycle(0, 8'h00, 1, 0, 0);
    chk("lit_pop1", 32'({pop_valid, pop_data}), 32'h133);
    cycle(0, 8'h00, 1, 0, 0);
    chk("lit_pop2", 32'({pop_valid, pop_data}), 32'h122);
    cycle(0, 8'h00, 1, 0, 0);
    chk("lit_pop3", 32'({pop_valid, pop_data}), 32'h111);
    chk("lit_pop_empty", 32'(empty), 32'd1);
    chk("lit_pop_top0", 32'(top_data), 32'd0);

    for (int i = 0; i < 17; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
    chk("lit_fill_full", 32'(full), 32'd1);
    chk("lit_fill_count", 32'(count), 32'd16);
    chk("lit_fill_ovf", 32'(overflow), 32'd1);
    cycle(1, 8'hAA, 1, 0, 0);
    chk("lit_replace_pop", 32'(pop_data), 32'h4F);
    chk("lit_replace_top", 32'(top_data), 32'hAA);
    chk("lit_replace_count", 32'(count), 32'd16);

    cycle(0, 8'h00, 0, 0, 1);
    chk("lit_ovf_clr", 32'(overflow), 32'd0);
    cycle(0, 8'h00, 0, 1, 0);
    cycle(0, 8'h00, 1, 0, 0);
    chk("lit_unf_set", 32'(underflow), 32'd1);
    chk("lit_unf_novalid", 32'(pop_valid), 32'd0);
    chk("lit_unf_hold", 32'(pop_data), 32'h4F);
    cycle(0, 8'h00, 0, 0, 1);
    chk("lit_unf_clr", 32'(underflow), 32'd0);
    cycle(0, 8'h00, 1, 0, 1);
    chk("lit_unf_setwins", 32'(underflow), 32'd1);
    cycle(0, 8'h00, 0, 0, 1);

    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h60 + i), 0, 0, 0);
    cycle(1, 8'h77, 0, 1, 0);
    chk("lit_flush_count", 32'(count), 32'd0);
    chk("lit_flush_empty", 32'(empty), 32'd1);
    chk("lit_flush_flags", 32'({overflow, underflow}), 32'd0);

    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h70 + i), 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    #1 rst = 1'b0;
    #1;
    chk("lit_async_valid", 32'(pop_valid), 32'd0);
    chk("lit_async_count", 32'(count), 32'd0);
    @(negedge clk);
    #1;
    cycle(0, 8'h00, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 200) % 3 == 0 ? 75 : ((i / 200) % 3 == 1 ? 50 : 25);
      cycle($urandom_range(99) < bias, 8'($urandom), $urandom_range(99) < (100 - bias) / 2 + 10,
            $urandom_range(39) == 0, $urandom_range(19) == 0);
      if (i == 1500) begin
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end

    cycle(0, 8'h00, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised hardware stack replacing the fixed 8-bit stack in the CPU core.
- Holds CALL return addresses and PUSH/POP operands for the decoder.
- Generalises width and depth over the fixed stack.
- Adds:
  - combinational peek of the top entry;
  - registered pop with a valid strobe;
  - simultaneous push/pop (replace top);
  - synchronous flush;
  - occupancy count;
  - sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, data bits per entry (>=1).
- DEPTH, 16, number of entries (>=2).
- CNT_W, $clog2(DEPTH+1), width of count and watermark. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- push_enable  input  1  push request this cycle.
- push_data  input  WIDTH  data to push.
- pop_enable  input  1  pop request this cycle.
- pop_data  output  WIDTH  registered popped value; holds its value between pops.
- pop_valid  output  1  one-cycle pulse, high the cycle after a successful pop.
- top_data  output  WIDTH  combinational: top entry; 0 when empty.
- flush  input  1  synchronous clear of stack contents.
- err_clr  input  1  clears the sticky error flags (and the watermark when enabled).
- count  output  CNT_W  current number of entries, 0..DEPTH.
- empty  output  1  count==0 (combinational from count).
- full  output  1  count==DEPTH (combinational from count).
- overflow  output  1  sticky: a push was attempted while full without a pop.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst low, asynchronous):
  - count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
  - Storage array is not reset. top_data reads 0 because empty=1.
- Storage and pointer:
  - mem[0..DEPTH-1]; entry k is written at index count.
  - Top entry is mem[count-1].
- Priority per cycle: flush > push/pop.
- Flush:
  - count<=0. pop_valid<=0.
  - Any push/pop in the same cycle is ignored; no error flags are set.
  - Sticky flags are unchanged.
- Push only:
  - If !full: mem[count]<=push_data, count<=count+1.
  - If full: write dropped, count unchanged, overflow<=1.
- Pop only:
  - If !empty: pop_data<=mem[count-1], pop_valid<=1 next cycle, count<=count-1.
  - If empty: underflow<=1, pop_data holds, pop_valid stays 0.
- Push and pop, not empty:
  - pop_data<=old top, pop_valid<=1.
  - mem[count-1]<=push_data; count unchanged.
  - Legal when full; no overflow.
- Push and pop, empty:
  - underflow<=1, no pop_valid.
  - Push is performed: mem[0]<=push_data, count<=1.
- pop_valid is low in every cycle not immediately following a successful pop.
- Push latency: top_data reflects a pushed value the cycle after the push edge.
- err_clr:
  - Clears overflow and underflow.
  - If an error occurs in the same cycle, set wins.
- Reset mid-operation: all outputs return to reset values immediately; the in-flight push/pop is lost.
- Pointer never wraps; count stays within 0..DEPTH under all input sequences.

Optional Feature:
- Macro: LIFO_STACK_WATERMARK_EN.
- Defined:
  - Adds output port hwm (CNT_W): highest count reached.
  - Reset value 0. Updated the cycle count exceeds it.
  - Cleared by err_clr (set wins if count rises the same cycle). Not cleared by flush.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset, then push 0x11,0x22,0x33 (WIDTH=8) -> count=3, top_data=0x33, empty=0, full=0.
- Pop three times back-to-back -> pop_data 0x33,0x22,0x11 on successive cycles with pop_valid high each; then empty=1, top_data=0.
- DEPTH=16:
  - Push 17 values -> full=1 after the 16th, count=16, overflow=1.
  - Then push+pop together with 0xAA -> pop_data=16th value, top_data=0xAA, count=16.
- From empty:
  - Pop -> underflow=1, pop_valid=0, pop_data unchanged.
  - err_clr -> underflow=0.
  - err_clr with a simultaneous empty pop -> underflow stays 1.
- With count=5, assert flush together with push -> count=0, empty=1, no flag change; assert rst low mid-pop -> pop_valid=0, count=0 asynchronously.
- With LIFO_STACK_WATERMARK_EN defined:
  - Push 9, pop 4 -> hwm=9.
  - Flush -> hwm=9.
  - err_clr -> hwm=0.
